fare_collector: RTL and testbench

Payment-side state machine for the ticket vending path. Takes the `total` and `ticket` results of the fare computation for one purchase and accepts coins until the fare is covered. It then issues one ticket pulse per ticket and returns change as a greedy sequence of coins over a valid/ready handshake. Sits between the destination/fare selector and the coin acceptor, ticket printer and coin hopper.

---
 rtl/fare_pkg.sv | 32 +++
 rtl/fare_collector_change_maker.sv | 23 ++
 rtl/fare_collector.sv | 145 ++++++++++++++
 tb/tb_fare_collector.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fare_pkg.sv
// Shared types and coin encoding for the fare payment path.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fare_pkg;

    // Coin codes, shared by the acceptor (coin_in_code) and the hopper (coin_out_code).
    localparam logic [1:0] C1  = 2'd0;
    localparam logic [1:0] C2  = 2'd1;
    localparam logic [1:0] C5  = 2'd2;
    localparam logic [1:0] C10 = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2,
        CHANGE  = 2'd3
    } fare_state_t;

    // The largest coin value fits in 4 bits. Callers widen the result to
    // their DW+1 accumulator width with a size cast at the call site.
    function automatic logic [3:0] coin_value(input logic [1:0] code);
        logic [3:0] v;
        case (code)
            C1:      v = 4'd1;
            C2:      v = 4'd2;
            C5:      v = 4'd5;
            default: v = 4'd10;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/fare_collector_change_maker.sv
// Greedy change selector: picks the largest coin not exceeding the amount owed.
// Latency: combinational, 0 cycles.
// Backpressure: none; the parent holds its input steady while the hopper stalls.
// Ports: change (amount owed) -> code (coin code), value (coin value, DW+1 bits).
module change_maker
    import fare_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW:0] change,
    output logic [1:0]  code,
    output logic [DW:0] value
);

    always_comb begin
        code = C1;
        if (change >= (DW+1)'(10))     code = C10;
        else if (change >= (DW+1)'(5)) code = C5;
        else if (change >= (DW+1)'(2)) code = C2;
        value = (DW+1)'(coin_value(code));
    end

endmodule

// File: rtl/fare_collector.sv
// Payment FSM: collects coins up to the fare, pulses one ticket_out per ticket, pays change/refunds greedily.
// Latency: start->busy 1 cycle; coin->paid 1 cycle; covered fare->ISSUE 1 more cycle; all outputs registered.
// Backpressure: change coins use valid/ready; code is held while coin_out_valid && !coin_out_ready.
// Ports: start/total/ticket (purchase request), cancel, coin_in_* (acceptor), coin_rej,
//        ticket_out (printer), coin_out_* (hopper), paid, busy, done.
module fare_collector
    import fare_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] total,
    input  logic [DW-1:0] ticket,
    input  logic          cancel,
    input  logic          coin_in_valid,
    input  logic [1:0]    coin_in_code,
    output logic          coin_rej,
    output logic          ticket_out,
    output logic          coin_out_valid,
    output logic [1:0]    coin_out_code,
    input  logic          coin_out_ready,
    output logic [DW:0]   paid,
    output logic          busy,
    output logic          done
);

    fare_state_t   state, state_d;
    logic [DW-1:0] total_q, total_d;
    logic [DW-1:0] tkt_q, tkt_d;
    logic [DW:0]   paid_d;
    logic [DW:0]   change_q, chg_d;
    logic [DW:0]   out_val_q;
    logic [DW:0]   coin_val;
    logic          rej_d, tkt_out_d, done_d;
    logic [1:0]    mk_code;
    logic [DW:0]   mk_val;

    assign coin_val = (DW+1)'(coin_value(coin_in_code));

    // Fed with the amount still owed after this cycle's handshake, so the
    // next coin is already chosen when coin_out_valid is re-registered.
    change_maker #(.DW(DW)) u_change_maker (
        .change (chg_d),
        .code   (mk_code),
        .value  (mk_val)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        total_d   = total_q;
        tkt_d     = tkt_q;
        paid_d    = paid;
        chg_d     = change_q;
        rej_d     = coin_in_valid;   // any coin not explicitly accepted goes back
        tkt_out_d = 1'b0;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (start && total != '0 && ticket != '0) begin
                    total_d = total;
                    tkt_d   = ticket;
                    paid_d  = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    // Refund everything; with nothing collected there is no change to pay.
                    chg_d = paid;
                    if (paid == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CHANGE;
                    end
                end else if (paid >= {1'b0, total_q}) begin
                    // Fare covered: a coin arriving now would not be in change_q, so it is returned.
                    chg_d   = paid - {1'b0, total_q};
                    state_d = ISSUE;
                end else if (coin_in_valid) begin
                    paid_d = paid + coin_val;
                    rej_d  = 1'b0;
                end
            end
            ISSUE: begin
                tkt_out_d = 1'b1;
                tkt_d     = tkt_q - DW'(1);
                if (tkt_q <= DW'(1)) begin
                    if (change_q != '0) begin
                        state_d = CHANGE;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            CHANGE: begin
                if (coin_out_valid && coin_out_ready && change_q >= out_val_q) begin
                    chg_d = change_q - out_val_q;
                    if (chg_d == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_q        <= '0;
            tkt_q          <= '0;
            paid           <= '0;
            change_q       <= '0;
            out_val_q      <= '0;
            coin_rej       <= 1'b0;
            ticket_out     <= 1'b0;
            coin_out_valid <= 1'b0;
            coin_out_code  <= C1;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            total_q        <= total_d;
            tkt_q          <= tkt_d;
            paid           <= paid_d;
            change_q       <= chg_d;
            out_val_q      <= mk_val;
            coin_rej       <= rej_d;
            ticket_out     <= tkt_out_d;
            coin_out_valid <= (state_d == CHANGE);
            coin_out_code  <= (state_d == CHANGE) ? mk_code : C1;
            busy           <= (state_d != IDLE);
            done           <= done_d;
        end
    end

endmodule

// File: tb/tb_fare_collector.sv
module tb_fare_collector;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] total;
    logic [DW-1:0] ticket;
    logic          cancel;
    logic          coin_in_valid;
    logic [1:0]    coin_in_code;
    logic          coin_rej;
    logic          ticket_out;
    logic          coin_out_valid;
    logic [1:0]    coin_out_code;
    logic          coin_out_ready;
    logic [DW:0]   paid;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    fare_collector #(.DW(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .total          (total),
        .ticket         (ticket),
        .cancel         (cancel),
        .coin_in_valid  (coin_in_valid),
        .coin_in_code   (coin_in_code),
        .coin_rej       (coin_rej),
        .ticket_out     (ticket_out),
        .coin_out_valid (coin_out_valid),
        .coin_out_code  (coin_out_code),
        .coin_out_ready (coin_out_ready),
        .paid           (paid),
        .busy           (busy),
        .done           (done)
    );

    int errors = 0;
    int checks = 0;

    // Observations collected by the monitor for the current purchase.
    int tkt_cnt, rej_cnt, done_cnt;
    int chg_obs[$];
    logic       prev_stall = 1'b0;
    logic [1:0] prev_code;

    // Expectations for the current purchase.
    int exp_chg[$];
    int e_paid, e_tkt, e_rej;
    int pc[8];
    int noise_coins;

    typedef struct {
        int total; int ticket; int n; logic [7:0] coins; int cmode; int stall;
        int e_paid; int e_tkt; int e_nchg; logic [7:0] e_chg; int e_rej;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int val(input int code);
        case (code)
            0: return 1;
            1: return 2;
            2: return 5;
            default: return 10;
        endcase
    endfunction

    function automatic logic [7:0] pk(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] c, input logic [1:0] d);
        return {d, c, b, a};
    endfunction

    always @(negedge clk) begin
        #2;
        if (rst !== 1'b0) begin
            prev_stall = 1'b0;
        end else begin
            if (ticket_out) tkt_cnt++;
            if (coin_rej)   rej_cnt++;
            if (done)       done_cnt++;
            if (coin_out_valid && coin_out_ready) chg_obs.push_back(int'(coin_out_code));
            if (prev_stall) chk("hold_under_stall", int'({coin_out_valid, coin_out_code}),
                                int'({1'b1, prev_code}));
            prev_stall = coin_out_valid && !coin_out_ready;
            prev_code  = coin_out_code;
        end
    end

    // Reference: coins count while the sum is short of the fare; later coins
    // bounce. Short of the fare means a cancel refunds the whole sum.
    task automatic model(input int tot, input int tk, input int n, input int cmode);
        int sum, c;
        sum = 0; e_rej = 0;
        for (int i = 0; i < n; i++) begin
            if (sum >= tot) e_rej++;
            else            sum += val(pc[i]);
        end
        if (sum >= tot) begin
            e_tkt = tk; c = sum - tot;
        end else begin
            e_tkt = 0; c = sum;
            if (cmode == 2) e_rej++;
        end
        e_paid = sum;
        exp_chg.delete();
        while (c > 0) begin
            if (c >= 10)     begin exp_chg.push_back(3); c -= 10; end
            else if (c >= 5) begin exp_chg.push_back(2); c -= 5;  end
            else if (c >= 2) begin exp_chg.push_back(1); c -= 2;  end
            else             begin exp_chg.push_back(0); c -= 1;  end
        end
    endtask

    task automatic run_purchase(input int tot, input int tk, input int n, input int cmode,
                                input int stall, input bit noise);
        int  stall_left;
        bit  finished;
        tkt_cnt = 0; rej_cnt = 0; done_cnt = 0; noise_coins = 0;
        chg_obs.delete();
        coin_out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; total = DW'(tot); ticket = DW'(tk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        for (int i = 0; i < n; i++) begin
            coin_in_valid = 1'b1; coin_in_code = 2'(pc[i]);
            @(negedge clk);
        end
        coin_in_valid = 1'b0;
        if (cmode != 0) begin
            cancel = 1'b1;
            if (cmode == 2) begin coin_in_valid = 1'b1; coin_in_code = 2'd3; end
            @(negedge clk);
            cancel = 1'b0; coin_in_valid = 1'b0;
        end
        stall_left = stall;
        finished   = 1'b0;
        for (int i = 0; i < 300 && !finished; i++) begin
            if (done) begin
                finished = 1'b1;
            end else begin
                if (coin_out_valid && stall_left > 0) begin
                    coin_out_ready = 1'b0; stall_left--;
                end else begin
                    coin_out_ready = noise ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                coin_in_valid = 1'b0;
                if (noise && $urandom_range(0, 7) == 0) begin
                    coin_in_valid = 1'b1; coin_in_code = 2'($urandom_range(0, 3)); noise_coins++;
                end
                start  = noise && ($urandom_range(0, 9) == 0);
                cancel = noise && (i >= 2) && ($urandom_range(0, 9) == 0);
                @(negedge clk);
            end
        end
        start = 1'b0; cancel = 1'b0; coin_in_valid = 1'b0;
        if (!finished) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_result();
        chk("paid", int'(paid), e_paid);
        chk("tickets", tkt_cnt, e_tkt);
        chk("coin_rej_count", rej_cnt, e_rej + noise_coins);
        chk("done_count", done_cnt, 1);
        chk("busy_after_done", int'(busy), 0);
        chk("change_count", chg_obs.size(), exp_chg.size());
        for (int i = 0; i < chg_obs.size() && i < exp_chg.size(); i++)
            chk("change_code", chg_obs[i], exp_chg[i]);
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] cs, ec;
        cs = v.coins; ec = v.e_chg;
        for (int j = 0; j < 4; j++) pc[j] = int'(cs[2*j +: 2]);
        exp_chg.delete();
        for (int j = 0; j < v.e_nchg; j++) exp_chg.push_back(int'(ec[2*j +: 2]));
        e_paid = v.e_paid; e_tkt = v.e_tkt; e_rej = v.e_rej;
        run_purchase(v.total, v.ticket, v.n, v.cmode, v.stall, 1'b0);
        check_result();
    endtask

    initial begin
        tbl[0] = '{total:6,  ticket:2, n:1, coins:pk(3,0,0,0), cmode:0, stall:0,
                   e_paid:10, e_tkt:2, e_nchg:2, e_chg:pk(1,1,0,0), e_rej:0};
        tbl[1] = '{total:6,  ticket:1, n:2, coins:pk(2,0,0,0), cmode:0, stall:0,
                   e_paid:6,  e_tkt:1, e_nchg:0, e_chg:8'd0,        e_rej:0};
        tbl[2] = '{total:20, ticket:1, n:2, coins:pk(2,1,0,0), cmode:1, stall:0,
                   e_paid:7,  e_tkt:0, e_nchg:2, e_chg:pk(2,1,0,0), e_rej:0};
        tbl[3] = '{total:20, ticket:1, n:3, coins:pk(3,2,1,0), cmode:1, stall:3,
                   e_paid:17, e_tkt:0, e_nchg:3, e_chg:pk(3,2,1,0), e_rej:0};
        tbl[4] = '{total:20, ticket:1, n:1, coins:pk(2,0,0,0), cmode:2, stall:0,
                   e_paid:5,  e_tkt:0, e_nchg:1, e_chg:pk(2,0,0,0), e_rej:1};
        tbl[5] = '{total:3,  ticket:3, n:2, coins:pk(3,0,0,0), cmode:0, stall:0,
                   e_paid:10, e_tkt:3, e_nchg:2, e_chg:pk(2,1,0,0), e_rej:1};
        tbl[6] = '{total:5,  ticket:1, n:0, coins:8'd0,        cmode:1, stall:0,
                   e_paid:0,  e_tkt:0, e_nchg:0, e_chg:8'd0,        e_rej:0};

        rst = 1'b1; start = 1'b0; total = '0; ticket = '0; cancel = 1'b0;
        coin_in_valid = 1'b0; coin_in_code = '0; coin_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_paid", int'(paid), 0);
        chk("rst_outputs", int'({coin_rej, ticket_out, coin_out_valid, coin_out_code, done}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Zero fare / zero tickets are ignored; a coin in IDLE bounces.
        start = 1'b1; total = '0; ticket = '0;
        @(negedge clk); start = 1'b0;
        chk("zero_fare_busy", int'(busy), 0);
        start = 1'b1; total = DW'(5); ticket = '0;
        @(negedge clk); start = 1'b0;
        chk("zero_ticket_busy", int'(busy), 0);
        coin_in_valid = 1'b1; coin_in_code = 2'd3;
        @(negedge clk); coin_in_valid = 1'b0;
        chk("idle_coin_rej", int'(coin_rej), 1);
        @(negedge clk);
        chk("idle_coin_rej_pulse", int'(coin_rej), 0);
        chk("idle_paid", int'(paid), 0);

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Reset while paying a refund: purchase dropped, outputs back to reset values.
        @(negedge clk);
        start = 1'b1; total = DW'(20); ticket = DW'(1);
        @(negedge clk); start = 1'b0;
        coin_in_valid = 1'b1; coin_in_code = 2'd3;
        @(negedge clk); coin_in_code = 2'd2;
        @(negedge clk); coin_in_valid = 1'b0; cancel = 1'b1;
        @(negedge clk); cancel = 1'b0; coin_out_ready = 1'b0;
        for (int i = 0; i < 10 && !coin_out_valid; i++) @(negedge clk);
        chk("reached_change", int'(coin_out_valid), 1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_paid", int'(paid), 0);
        chk("midrst_outputs", int'({coin_rej, ticket_out, coin_out_valid, coin_out_code, done}), 0);
        @(negedge clk);
        chk("midrst_stays_idle", int'(busy), 0);
        run_vec(tbl[0]);

        // Randomized purchases with stray start/cancel/coins and random hopper readiness.
        for (int r = 0; r < 40; r++) begin
            int tot, tk, n, sum, maxc, cmode;
            tot  = $urandom_range(1, 30);
            tk   = $urandom_range(1, 3);
            maxc = $urandom_range(0, 7);
            n = 0; sum = 0;
            while (n < maxc && sum < tot) begin
                pc[n] = $urandom_range(0, 3);
                sum += val(pc[n]);
                n++;
            end
            if (sum >= tot && $urandom_range(0, 1) == 1) begin
                pc[n] = $urandom_range(0, 3);
                n++;
            end
            cmode = (sum < tot) ? $urandom_range(1, 2) : 0;
            model(tot, tk, n, cmode);
            run_purchase(tot, tk, n, cmode, 0, 1'b1);
            check_result();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
